// File: rtl/jtag_dr_ir_regs_if.sv
// Bus between the TAP controller side and the IR/DR register bank.
// master: TAP side (drives tdi, state decodes, user_cap; receives tdo/tdo_en, ir_q, user_q, user_upd)
// slave : jtag_dr_ir_regs
interface jtag_dr_ir_regs_if #(
  parameter int unsigned IR_W   = 4,
  parameter int unsigned USER_W = 16
) ();
  logic              tdi;
  logic              test_logic_reset;
  logic              capture_dr;
  logic              shift_dr;
  logic              update_dr;
  logic              capture_ir;
  logic              shift_ir;
  logic              update_ir;
  logic [USER_W-1:0] user_cap;
  logic              tdo;
  logic              tdo_en;
  logic [IR_W-1:0]   ir_q;
  logic [USER_W-1:0] user_q;
  logic              user_upd;

  modport master (
    output tdi, test_logic_reset, capture_dr, shift_dr, update_dr,
           capture_ir, shift_ir, update_ir, user_cap,
    input  tdo, tdo_en, ir_q, user_q, user_upd
  );

  modport slave (
    input  tdi, test_logic_reset, capture_dr, shift_dr, update_dr,
           capture_ir, shift_ir, update_ir, user_cap,
    output tdo, tdo_en, ir_q, user_q, user_upd
  );
endinterface

// File: rtl/jtag_dr_ir_regs.sv
// JTAG instruction register plus IDCODE / BYPASS / optional USER data registers.
// Sits downstream of the TAP FSM and consumes its one-hot state decodes.
// Ports:
//   tclk  - test clock, all state changes on rising edge
//   trst  - synchronous active-high reset, highest priority
//   bus   - jtag_dr_ir_regs_if.slave: tdi, TAP decodes, user_cap in;
//           tdo (combinational), tdo_en, ir_q, user_q, user_upd out
// Build option: define JTAG_USER_DR_EN to build the USER data register;
// otherwise OP_USER falls through to BYPASS and user_q/user_upd are tied 0.
module jtag_dr_ir_regs #(
  parameter int unsigned     IR_W      = 4,
  parameter logic [31:0]     IDCODE    = 32'h1000_0001,
  parameter int unsigned     USER_W    = 16,
  parameter logic [IR_W-1:0] OP_IDCODE = IR_W'(4'h1),
  parameter logic [IR_W-1:0] OP_USER   = IR_W'(4'h8),
  parameter logic [IR_W-1:0] OP_BYPASS = IR_W'(4'hF)
) (
  input  logic                tclk,
  input  logic                trst,
  jtag_dr_ir_regs_if.slave    bus
);

  localparam int unsigned ID_W = 32;

  logic [IR_W-1:0] ir_sh_q, ir_sh_d;
  logic [IR_W-1:0] ir_q_q, ir_q_d;
  logic [ID_W-1:0] id_sh_q, id_sh_d;
  logic            byp_sh_q, byp_sh_d;

  logic sel_id;
  logic sel_user;
  logic user_lsb;
  logic ir_busy;
  logic dr_cap;
  logic dr_sh;
  logic dr_upd;

  // Decode priority: any IR-side or reset decode masks the DR-side ones.
  assign ir_busy = bus.test_logic_reset | bus.capture_ir | bus.shift_ir | bus.update_ir;
  assign dr_cap  = bus.capture_dr & ~ir_busy;
  assign dr_sh   = bus.shift_dr & ~ir_busy & ~bus.capture_dr;
  assign dr_upd  = bus.update_dr & ~ir_busy & ~bus.capture_dr & ~bus.shift_dr;

  // Anything that is neither IDCODE nor (enabled) USER lands on BYPASS, OP_BYPASS included.
  assign sel_id = (ir_q_q == OP_IDCODE);

  // IR and always-present DR next state.
  always_comb begin
    ir_sh_d  = ir_sh_q;
    ir_q_d   = ir_q_q;
    id_sh_d  = id_sh_q;
    byp_sh_d = byp_sh_q;
    if (bus.test_logic_reset) begin
      ir_sh_d  = '0;
      ir_q_d   = OP_IDCODE;
      id_sh_d  = '0;
      byp_sh_d = 1'b0;
    end else if (bus.capture_ir) begin
      ir_sh_d = IR_W'(2'b01);
    end else if (bus.shift_ir) begin
      ir_sh_d = {bus.tdi, ir_sh_q[IR_W-1:1]};
    end else if (bus.update_ir) begin
      ir_q_d = ir_sh_q;
    end else if (dr_cap) begin
      if (sel_id) begin
        id_sh_d = IDCODE;
      end else if (!sel_user) begin
        byp_sh_d = 1'b0;
      end
    end else if (dr_sh) begin
      if (sel_id) begin
        id_sh_d = {bus.tdi, id_sh_q[ID_W-1:1]};
      end else if (!sel_user) begin
        byp_sh_d = bus.tdi;
      end
    end
  end

  // State register.
  always_ff @(posedge tclk) begin
    if (trst) begin
      ir_sh_q  <= '0;
      ir_q_q   <= OP_IDCODE;
      id_sh_q  <= '0;
      byp_sh_q <= 1'b0;
    end else begin
      ir_sh_q  <= ir_sh_d;
      ir_q_q   <= ir_q_d;
      id_sh_q  <= id_sh_d;
      byp_sh_q <= byp_sh_d;
    end
  end

`ifdef JTAG_USER_DR_EN
  logic [USER_W-1:0] user_sh_q, user_sh_d;
  logic [USER_W-1:0] user_q_q, user_q_d;
  logic              user_upd_q, user_upd_d;

  assign sel_user = (ir_q_q == OP_USER);
  assign user_lsb = user_sh_q[0];

  // USER register next state; user_q survives test_logic_reset.
  always_comb begin
    user_sh_d  = user_sh_q;
    user_q_d   = user_q_q;
    user_upd_d = 1'b0;
    if (bus.test_logic_reset) begin
      user_sh_d = '0;
    end else if (sel_user) begin
      if (dr_cap) begin
        user_sh_d = bus.user_cap;
      end else if (dr_sh) begin
        user_sh_d = {bus.tdi, user_sh_q[USER_W-1:1]};
      end else if (dr_upd) begin
        user_q_d   = user_sh_q;
        user_upd_d = 1'b1;
      end
    end
  end

  always_ff @(posedge tclk) begin
    if (trst) begin
      user_sh_q  <= '0;
      user_q_q   <= '0;
      user_upd_q <= 1'b0;
    end else begin
      user_sh_q  <= user_sh_d;
      user_q_q   <= user_q_d;
      user_upd_q <= user_upd_d;
    end
  end

  assign bus.user_q   = user_q_q;
  assign bus.user_upd = user_upd_q;
`else
  logic unused_user;

  assign sel_user     = 1'b0;
  assign user_lsb     = 1'b0;
  assign bus.user_q   = '0;
  assign bus.user_upd = 1'b0;
  assign unused_user  = ^{bus.user_cap, dr_upd};
`endif

  // Serial out: IR shift wins, then the selected DR's LSB.
  always_comb begin
    bus.tdo = 1'b0;
    if (bus.shift_ir) begin
      bus.tdo = ir_sh_q[0];
    end else if (bus.shift_dr) begin
      if (sel_id) begin
        bus.tdo = id_sh_q[0];
      end else if (sel_user) begin
        bus.tdo = user_lsb;
      end else begin
        bus.tdo = byp_sh_q;
      end
    end
  end

  assign bus.tdo_en = bus.shift_dr | bus.shift_ir;
  assign bus.ir_q   = ir_q_q;

endmodule

// File: doc/jtag_dr_ir_regs.md
# jtag_dr_ir_regs

Instruction register and test-data-register bank that sits directly downstream of the TAP controller FSM. It consumes the controller's one-hot state decodes (capture/shift/update for IR and DR, plus test-logic-reset), shifts TDI through the selected register, and drives TDO. It also presents the latched instruction and an optional user data register to the rest of the design.

## Interface
- IR_W, 4, instruction register width (≥2)
- IDCODE, 32'h1000_0001, device ID value; bit 0 must be 1
- USER_W, 16, user data register width
- OP_IDCODE, 4'h1, IDCODE opcode (IR_W bits)
- OP_USER, 4'h8, USER opcode (IR_W bits)
- OP_BYPASS, 4'hF, BYPASS opcode (all ones)

Ports:
- tclk  in  1  test clock; all state changes on rising edge
- trst  in  1  reset; synchronous, active-high
- tdi  in  1  serial test data in
- test_logic_reset  in  1  TAP state decode
- capture_dr, shift_dr, update_dr  in  1 each  TAP DR state decodes
- capture_ir, shift_ir, update_ir  in  1 each  TAP IR state decodes
- user_cap  in  USER_W  value loaded into the user shift register on capture_dr
- tdo  out  1  serial data out
- tdo_en  out  1  high while shift_dr or shift_ir is high
- ir_q  out  IR_W  active (updated) instruction
- user_q  out  USER_W  latched user DR value
- user_upd  out  1  one-cycle strobe: user_q was just written

## Operation
- Registers: ir_sh (IR_W), ir_q (IR_W), id_sh (32), byp_sh (1), user_sh (USER_W), user_q (USER_W), user_upd.
- Reset values when trst=1 or test_logic_reset=1 at a rising edge: ir_q=OP_IDCODE, ir_sh=0, id_sh=0, byp_sh=0, user_sh=0, user_upd=0. user_q is cleared by trst only and holds through test_logic_reset. trst has priority over all other inputs.
- DR selection decodes from ir_q: OP_IDCODE selects id_sh, OP_USER selects user_sh, and any other code selects byp_sh.
- capture_ir loads ir_sh = {0…0, 2'b01}.
- capture_dr loads the selected register: id_sh=IDCODE, byp_sh=0, user_sh=user_cap. Unselected registers hold.
- In shift_ir or shift_dr, the register shifts right: tdi enters the MSB and the LSB leaves. byp_sh simply becomes tdi.
- update_ir sets ir_q = ir_sh.
- update_dr with OP_USER sets user_q = user_sh and user_upd=1 on the same edge. user_upd returns to 0 on the next edge. Under any other instruction, update_dr has no effect.
- tdo is combinational:
  - shift_ir high: ir_sh[0]
  - shift_dr high: LSB of the selected DR
  - otherwise: 0
- Input decodes are one-hot by contract. If more than one is high, priority is: trst > test_logic_reset > capture_ir > shift_ir > update_ir > capture_dr > shift_dr > update_dr.

## Timing
- Capture, shift and update each take effect on the rising edge on which the decode is high.
- Shift latency: a bit presented on tdi at edge k appears on tdo after N edges, where N is the selected register length (IR_W, 32, 1 or USER_W).
- ir_q changes on the update_ir edge. The DR selection for the next capture_dr uses the new value.
- A reset in mid-shift discards the partial shift with no update. ir_q returns to OP_IDCODE.
- user_upd is high for exactly one cycle per qualifying update_dr.

## Configuration
- JTAG_USER_DR_EN defined: user_sh, user_q and user_upd are built, and OP_USER selects the user DR.
- JTAG_USER_DR_EN undefined: no user registers exist. user_q and user_upd are tied to 0, user_cap is ignored, and OP_USER selects BYPASS (1-bit DR).

## Test plan
- Pulse trst, then capture_dr and shift 32 cycles -> tdo emits IDCODE LSB-first, with 1 as the first bit (for 32'h1000_0001).
- capture_ir, then shift 4 cycles with tdi=1,1,1,1, then update_ir -> capture pattern 1,0,0,0 seen on tdo; ir_q=4'hF. Then capture_dr and shift tdi=1,0,1 -> tdo=0,1,0 (one-bit delay).
- Load OP_USER, capture with user_cap=16'hA5C3, then shift 16 bits of 16'h1234 -> tdo streams A5C3 LSB-first. update_dr -> user_q=16'h1234 and user_upd high for exactly 1 cycle.
- Assert test_logic_reset while ir_q=OP_USER -> ir_q=OP_IDCODE next edge; user_q unchanged; a later capture_dr loads IDCODE.
- Assert trst after 5 cycles of a 16-bit user shift -> no user_upd pulse; user_q=0; ir_q=OP_IDCODE.
- Build without JTAG_USER_DR_EN and load OP_USER -> DR acts as a 1-bit bypass; user_q=0 and user_upd=0 throughout.
